// File: rtl/rv_mem_arb.sv
// Round-robin arbiter sharing one req/ack memory port between the core
// and the debug/loader requester, with per-access timeout abort.
module rv_mem_arb #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int TIMEOUT = 15,
  parameter logic [DW-1:0] ERR_DATA = DW'(32'hDEADBEEF)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          core_req,
  input  logic          core_we,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  output logic [DW-1:0] core_rdata,
  output logic          core_done,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic [DW-1:0] dbg_rdata,
  output logic          dbg_done,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          owner,
  output logic          err
);

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    RESP
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t        state_q;
  state_t        state_d;
  logic          owner_q;
  logic          err_q;
  logic [7:0]    cnt_q;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] core_rd_q;
  logic [DW-1:0] dbg_rd_q;

  logic          grant;
  logic          gnt_dbg;
  logic          tmo;
  logic          fin;
  logic [DW-1:0] resp_data;

  always_comb begin
    state_d   = state_q;
    grant     = 1'b0;
    tmo       = 1'b0;
    fin       = 1'b0;
    // on a tie the requester that did not go last wins
    gnt_dbg   = dbg_req & (~core_req | ~owner_q);
    resp_data = ERR_DATA;
    unique case (state_q)
      IDLE: begin
        if (core_req | dbg_req) begin
          grant   = 1'b1;
          state_d = ACC;
        end
      end
      ACC: begin
        if (mem_ack) begin
          fin       = 1'b1;
          resp_data = we_q ? '0 : mem_rdata;
          state_d   = RESP;
        end else if (cnt_q == TMO_LAST) begin
          fin     = 1'b1;
          tmo     = 1'b1;
          state_d = RESP;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      owner_q   <= 1'b1;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      core_rd_q <= '0;
      dbg_rd_q  <= '0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        owner_q <= gnt_dbg;
        we_q    <= gnt_dbg ? dbg_we : core_we;
        addr_q  <= gnt_dbg ? dbg_addr : core_addr;
        wdata_q <= gnt_dbg ? dbg_wdata : core_wdata;
        cnt_q   <= '0;
      end
      if (state_q == ACC && !fin) begin
        cnt_q <= cnt_q + 8'd1;
      end
      if (fin) begin
        if (owner_q) begin
          dbg_rd_q <= resp_data;
        end else begin
          core_rd_q <= resp_data;
        end
      end
      if (tmo) begin
        err_q <= 1'b1;
      end
    end
  end

  assign mem_req    = (state_q == ACC);
  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign core_done  = (state_q == RESP) & ~owner_q;
  assign dbg_done   = (state_q == RESP) & owner_q;
  assign core_rdata = core_rd_q;
  assign dbg_rdata  = dbg_rd_q;
  assign owner      = owner_q;
  assign err        = err_q;

endmodule

// File: tb/tb_rv_mem_arb.sv
// Bench for rv_mem_arb: directed scenarios plus a randomized run
// checked against a transaction-level model of the arbiter.
module tb_rv_mem_arb;

  localparam int T = 15;
  localparam logic [31:0] ERRD = 32'hDEADBEEF;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic core_req = 0, core_we = 0, dbg_req = 0, dbg_we = 0;
  logic [31:0] core_addr = 0, core_wdata = 0, dbg_addr = 0, dbg_wdata = 0;
  logic [31:0] core_rdata, dbg_rdata, mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 0;
  logic core_done, dbg_done, mem_req, mem_we, owner, err;
  logic mem_ack = 0;

  int errors = 0;
  int checks = 0;

  // results of the last serve() call
  int r_start, r_n, r_done_at, r_cdn, r_ddn;
  logic r_own, r_we;
  logic [31:0] r_addr, r_wdata, r_crd, r_drd;
  bit r_stable;

  rv_mem_arb #(
    .AW(32), .DW(32), .TIMEOUT(T), .ERR_DATA(ERRD)
  ) dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_rdata(core_rdata), .core_done(core_done),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_rdata(dbg_rdata), .dbg_done(dbg_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .owner(owner), .err(err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    {core_req, core_we, dbg_req, dbg_we, mem_ack} = '0;
    {core_addr, core_wdata, dbg_addr, dbg_wdata, mem_rdata} = '0;
    step();
    step();
    rst = 1'b1;
  endtask

  // Plays the memory for one access starting from an IDLE cycle. Acks in
  // ACC cycle ack_at (never if > T); scrambles requester inputs meanwhile.
  task automatic serve(input int ack_at, input logic [31:0] rd,
                       input logic kc, input logic kd);
    bit fin = 0;
    r_start = 0; r_n = 0; r_done_at = 0; r_cdn = 0; r_ddn = 0;
    r_own = 0; r_we = 0; r_addr = 0; r_wdata = 0;
    r_crd = 0; r_drd = 0; r_stable = 1;
    for (int cyc = 1; cyc <= 300 && !fin; cyc++) begin
      step();
      r_cdn += int'(core_done);
      r_ddn += int'(dbg_done);
      if (mem_req === 1'b1) begin
        r_n++;
        if (r_n == 1) begin
          r_start = cyc; r_own = owner; r_we = mem_we;
          r_addr = mem_addr; r_wdata = mem_wdata;
        end else if (mem_we !== r_we || mem_addr !== r_addr ||
                     mem_wdata !== r_wdata || owner !== r_own) begin
          r_stable = 0;
        end
        mem_ack   = (r_n == ack_at);
        mem_rdata = (r_n == ack_at) ? rd : $urandom;
        core_req = $urandom; dbg_req = $urandom;
        core_we = $urandom; dbg_we = $urandom;
        core_addr = $urandom; core_wdata = $urandom;
        dbg_addr = $urandom; dbg_wdata = $urandom;
      end else begin
        if (r_n > 0) begin
          r_done_at = cyc;
          r_crd = core_rdata;
          r_drd = dbg_rdata;
        end
        mem_ack = 0;
        core_req = kc;
        dbg_req = kd;
        if (r_n > 0) begin
          step();
          r_cdn += int'(core_done);
          r_ddn += int'(dbg_done);
        end
        fin = 1;
      end
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({mem_req, mem_we, core_done, dbg_done, owner, err} !== 6'b000010) begin
      errors++;
      $display("FAIL rst_ctl: got %b want 000010",
               {mem_req, mem_we, core_done, dbg_done, owner, err});
    end
    checks++;
    if ({mem_addr, mem_wdata} !== 64'h0) begin
      errors++;
      $display("FAIL rst_mem: got %h want 0", {mem_addr, mem_wdata});
    end
    checks++;
    if ({core_rdata, dbg_rdata} !== 64'h0) begin
      errors++;
      $display("FAIL rst_rdata: got %h want 0", {core_rdata, dbg_rdata});
    end
    step();
    step();
    checks++;
    if (mem_req !== 1'b0) begin
      errors++;
      $display("FAIL idle_noreq: got %b want 0", mem_req);
    end
  endtask

  task automatic test_zero_wait();
    core_req = 1; core_we = 0; core_addr = 32'h100; dbg_req = 0;
    serve(1, 32'h12345678, 1'b0, 1'b0);
    checks++;
    if (r_start !== 1 || r_n !== 1 || r_done_at !== 2) begin
      errors++;
      $display("FAIL zw_timing: got start=%0d len=%0d done=%0d want 1 1 2",
               r_start, r_n, r_done_at);
    end
    checks++;
    if (r_addr !== 32'h100 || r_we !== 1'b0) begin
      errors++;
      $display("FAIL zw_addr: got %h we=%b want 100 we=0", r_addr, r_we);
    end
    checks++;
    if (r_cdn !== 1 || r_ddn !== 0) begin
      errors++;
      $display("FAIL zw_done: got core=%0d dbg=%0d want 1 0", r_cdn, r_ddn);
    end
    checks++;
    if (r_crd !== 32'h12345678 || r_drd !== 32'h0) begin
      errors++;
      $display("FAIL zw_rdata: got %h %h want 12345678 0", r_crd, r_drd);
    end
  endtask

  task automatic test_round_robin();
    logic g;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      g = (i % 2 == 1);
      core_req = 1; core_we = 0; core_addr = 32'h300; core_wdata = 0;
      dbg_req = 1; dbg_we = 1; dbg_addr = 32'h200; dbg_wdata = 32'hA5A5A5A5;
      serve(3, 32'h1000 + i, i < 3, i < 3);
      checks++;
      if (r_own !== g || r_start !== 1) begin
        errors++;
        $display("FAIL rr_grant%0d: got owner=%b start=%0d want %b 1",
                 i, r_own, r_start, g);
      end
      checks++;
      if (r_we !== g || r_wdata !== (g ? 32'hA5A5A5A5 : 32'h0) ||
          r_addr !== (g ? 32'h200 : 32'h300)) begin
        errors++;
        $display("FAIL rr_bus%0d: got we=%b a=%h d=%h", i, r_we, r_addr, r_wdata);
      end
      checks++;
      if (r_cdn !== int'(!g) || r_ddn !== int'(g) || r_n !== 3) begin
        errors++;
        $display("FAIL rr_done%0d: got %0d %0d len=%0d", i, r_cdn, r_ddn, r_n);
      end
      if (!g) begin
        checks++;
        if (r_crd !== 32'h1000 + i) begin
          errors++;
          $display("FAIL rr_rdata%0d: got %h want %h", i, r_crd, 32'h1000 + i);
        end
      end
    end
  endtask

  task automatic test_stable();
    core_req = 1; core_we = 1; core_addr = 32'h400; core_wdata = 32'h11112222;
    dbg_req = 0;
    serve(5, 32'hFFFF0000, 1'b0, 1'b0);
    checks++;
    if (r_stable !== 1'b1 || r_addr !== 32'h400 || r_wdata !== 32'h11112222 ||
        r_we !== 1'b1) begin
      errors++;
      $display("FAIL hold: got stable=%b a=%h d=%h we=%b",
               r_stable, r_addr, r_wdata, r_we);
    end
    checks++;
    if (r_crd !== 32'h0 || r_n !== 5) begin
      errors++;
      $display("FAIL hold_wr: got rdata=%h len=%0d want 0 5", r_crd, r_n);
    end
  endtask

  task automatic test_timeout();
    core_req = 1; core_we = 0; core_addr = 32'h500; dbg_req = 0;
    serve(100, 32'h0, 1'b0, 1'b0);
    checks++;
    if (r_n !== T || r_done_at !== T + 1 || r_cdn !== 1) begin
      errors++;
      $display("FAIL to_timing: got len=%0d done=%0d n=%0d want %0d %0d 1",
               r_n, r_done_at, r_cdn, T, T + 1);
    end
    checks++;
    if (r_crd !== ERRD || err !== 1'b1) begin
      errors++;
      $display("FAIL to_data: got %h err=%b want deadbeef 1", r_crd, err);
    end
    core_req = 1; core_we = 0; core_addr = 32'h504;
    serve(2, 32'h600DD00D, 1'b0, 1'b0);
    checks++;
    if (r_crd !== 32'h600DD00D || err !== 1'b1) begin
      errors++;
      $display("FAIL to_after: got %h err=%b want 600dd00d 1", r_crd, err);
    end
  endtask

  task automatic test_reset_mid();
    int dn = 0;
    int rq = 0;
    core_req = 1; core_we = 0; core_addr = 32'h700; dbg_req = 0;
    step();
    step();
    core_req = 0;
    #2;
    rst = 0;
    #1;
    checks++;
    if ({mem_req, mem_we, core_done, dbg_done, owner, err} !== 6'b000010 ||
        {mem_addr, mem_wdata, core_rdata, dbg_rdata} !== 128'h0) begin
      errors++;
      $display("FAIL mid_rst: got %b %h", {mem_req, mem_we, core_done,
               dbg_done, owner, err}, {mem_addr, mem_wdata, core_rdata, dbg_rdata});
    end
    mem_ack = 1; mem_rdata = 32'h55;
    step();
    rst = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      dn += int'(core_done) + int'(dbg_done);
      rq += int'(mem_req);
    end
    mem_ack = 0;
    checks++;
    if (dn !== 0 || rq !== 0 || core_rdata !== 32'h0) begin
      errors++;
      $display("FAIL late_ack: got done=%0d req=%0d rdata=%h want 0 0 0",
               dn, rq, core_rdata);
    end
    core_req = 1; core_we = 0; core_addr = 32'h800;
    dbg_req = 1; dbg_we = 0; dbg_addr = 32'h900;
    serve(1, 32'h77, 1'b0, 1'b0);
    checks++;
    if (r_own !== 1'b0 || r_cdn !== 1 || r_crd !== 32'h77) begin
      errors++;
      $display("FAIL post_tie: got owner=%b done=%0d rdata=%h want 0 1 77",
               r_own, r_cdn, r_crd);
    end
  endtask

  task automatic test_ack_last();
    core_req = 1; core_we = 0; core_addr = 32'hA00; dbg_req = 0;
    serve(T, 32'h15151515, 1'b0, 1'b0);
    checks++;
    if (r_n !== T || r_crd !== 32'h15151515 || err !== 1'b0) begin
      errors++;
      $display("FAIL ack_last: got len=%0d rdata=%h err=%b want %0d 15151515 0",
               r_n, r_crd, err, T);
    end
  endtask

  task automatic test_random();
    logic m_owner, m_err, cr, dr, cw, dw, g, e_we, to;
    logic [31:0] m_crd, m_drd, ca, cd, da, dd, rd, e_addr, e_wd, e_data;
    int ack_at, e_n;
    apply_reset();
    m_owner = 1; m_err = 0; m_crd = 0; m_drd = 0;
    for (int i = 0; i < 60; i++) begin
      cr = $urandom; dr = $urandom; cw = $urandom; dw = $urandom;
      ca = $urandom; cd = $urandom; da = $urandom; dd = $urandom;
      rd = $urandom;
      ack_at = $urandom_range(1, T + 3);
      core_req = cr; core_we = cw; core_addr = ca; core_wdata = cd;
      dbg_req = dr; dbg_we = dw; dbg_addr = da; dbg_wdata = dd;
      g = (cr && dr) ? !m_owner : dr;
      e_we = g ? dw : cw;
      e_addr = g ? da : ca;
      e_wd = g ? dd : cd;
      to = (ack_at > T);
      e_n = to ? T : ack_at;
      e_data = to ? ERRD : (e_we ? 32'h0 : rd);
      if (cr || dr) begin
        if (g) m_drd = e_data;
        else m_crd = e_data;
        m_owner = g;
        m_err = m_err | to;
      end
      serve(ack_at, rd, 1'b0, 1'b0);
      if (cr || dr) begin
        checks++;
        if (r_own !== g || r_addr !== e_addr || r_we !== e_we ||
            r_wdata !== e_wd || r_stable !== 1'b1) begin
          errors++;
          $display("FAIL rnd_bus%0d: got o=%b a=%h we=%b d=%h s=%b want %b %h %b %h",
                   i, r_own, r_addr, r_we, r_wdata, r_stable, g, e_addr, e_we, e_wd);
        end
        checks++;
        if (r_n !== e_n || r_done_at !== e_n + 1 ||
            r_cdn !== int'(!g) || r_ddn !== int'(g)) begin
          errors++;
          $display("FAIL rnd_time%0d: got len=%0d done@%0d c=%0d d=%0d want %0d",
                   i, r_n, r_done_at, r_cdn, r_ddn, e_n);
        end
        checks++;
        if (r_crd !== m_crd || r_drd !== m_drd || err !== m_err) begin
          errors++;
          $display("FAIL rnd_data%0d: got %h %h err=%b want %h %h %b",
                   i, r_crd, r_drd, err, m_crd, m_drd, m_err);
        end
      end else begin
        checks++;
        if (r_n !== 0 || r_cdn + r_ddn !== 0) begin
          errors++;
          $display("FAIL rnd_idle%0d: got len=%0d done=%0d want 0", i,
                   r_n, r_cdn + r_ddn);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_round_robin();
    test_stable();
    test_timeout();
    test_reset_mid();
    test_ack_last();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

endmodule
